// File: rtl/pipe_fetch_ctrl.sv
// Fetch and pipeline-control unit for the LC-3b pipeline: owns the PC and the fetch handshake,
// and drives per-stage load enables and valid bits for data stalls, load-use bubbles and branch flushes.
module pipe_fetch_ctrl #(
  parameter int               WIDTH     = 16,
  parameter int               NSTAGES   = 5,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 inst_mem_read,
  output logic [WIDTH-1:0]     inst_mem_addr,
  input  logic                 inst_mem_resp,
  input  logic [WIDTH-1:0]     inst_mem_rdata,
  input  logic                 data_req,
  input  logic                 data_mem_resp,
  output logic                 data_mem_go,
  input  logic                 br_taken,
  input  logic [WIDTH-1:0]     br_target,
  input  logic [2:0]           id_src_a,
  input  logic [2:0]           id_src_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 id_is_load,
  input  logic [2:0]           id_dest,
  output logic [WIDTH-1:0]     if_ir,
  output logic [WIDTH-1:0]     if_pc,
  output logic [NSTAGES-2:0]   stage_load,
  output logic [NSTAGES-2:0]   stage_valid,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int NR  = NSTAGES - 1;
  localparam int MEM = NSTAGES - 3;
  localparam int WB  = NSTAGES - 2;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  fetch_state_t    state, state_next;
  logic [WIDTH-1:0] pc, pc_next, pc_plus2;
  logic [WIDTH-1:0] hold_ir, hold_ir_next;
  logic [WIDTH-1:0] redir, redir_next;
  logic             fetch_valid;
  logic [NR-1:0]    valid_next;

  logic             mvalid, dstall, flush, luh, adv, hazard_hit;

  // Shadow of the load/dest fields for regs 1..MEM-1; validity comes from stage_valid.
  logic             sh_load [1:MEM-1];
  logic [2:0]       sh_dest [1:MEM-1];

  assign pc_plus2      = pc + WIDTH'(2);
  assign inst_mem_addr = pc;
  assign mvalid        = stage_valid[MEM];
  assign dstall        = mvalid & data_req & ~data_mem_resp;
  assign flush         = mvalid & br_taken & ~dstall;
  assign luh           = ~flush & stage_valid[0] & hazard_hit;
  assign adv           = flush | (~dstall & ~luh);
  assign data_mem_go   = mvalid & data_req;

  always_comb begin
    hazard_hit = 1'b0;
    for (int k = 1; k < MEM; k++) begin
      if (stage_valid[k] && sh_load[k] &&
          ((id_use_a && (id_src_a == sh_dest[k])) || (id_use_b && (id_src_b == sh_dest[k]))))
        hazard_hit = 1'b1;
    end
  end

  always_comb begin
    stage_load = '1;
    if (dstall) begin
      stage_load     = '0;
      stage_load[WB] = 1'b1;
    end else if (luh) begin
      stage_load[0] = 1'b0;
    end
  end

  always_comb begin
    valid_next = stage_valid;
    if (dstall) begin
      valid_next[WB] = 1'b0;
    end else if (flush) begin
      valid_next     = '0;
      valid_next[WB] = 1'b1;
    end else if (luh) begin
      valid_next    = {stage_valid[NR-2:0], stage_valid[0]};
      valid_next[1] = 1'b0;
    end else begin
      valid_next = {stage_valid[NR-2:0], fetch_valid};
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    hold_ir_next  = hold_ir;
    redir_next    = redir;
    fetch_valid   = 1'b0;
    inst_mem_read = ~reset;
    if_ir         = inst_mem_rdata;
    if_pc         = pc_plus2;
    case (state)
      FETCH: begin
        if (inst_mem_resp) begin
          if (flush) begin
            pc_next = br_target;
          end else if (adv) begin
            fetch_valid = 1'b1;
            pc_next     = pc_plus2;
          end else begin
            hold_ir_next = inst_mem_rdata;
            pc_next      = pc_plus2;
            state_next   = HOLD;
          end
        end else if (flush) begin
          redir_next = br_target;
          state_next = REDIRECT;
        end
      end
      HOLD: begin
        inst_mem_read = 1'b0;
        if_ir         = hold_ir;
        if_pc         = pc;
        if (flush) begin
          pc_next    = br_target;
          state_next = FETCH;
        end else if (adv) begin
          fetch_valid = 1'b1;
          state_next  = FETCH;
        end
      end
      REDIRECT: begin
        // The outstanding fetch must complete before the address may move.
        if (inst_mem_resp) begin
          pc_next    = flush ? br_target : redir;
          state_next = FETCH;
        end else if (flush) begin
          redir_next = br_target;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_ir     <= '0;
      redir       <= RESET_PC;
      stage_valid <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      hold_ir     <= hold_ir_next;
      redir       <= redir_next;
      stage_valid <= valid_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k < MEM; k++) begin
        sh_load[k] <= 1'b0;
        sh_dest[k] <= '0;
      end
    end else begin
      if (stage_load[1]) begin
        sh_load[1] <= stage_valid[0] & id_is_load & ~luh & ~flush;
        sh_dest[1] <= id_dest;
      end
      for (int k = 2; k < MEM; k++) begin
        if (stage_load[k]) begin
          sh_load[k] <= sh_load[k-1];
          sh_dest[k] <= sh_dest[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if ((dstall | luh) && !(&stall_count))
      stall_count <= stall_count + CNT_WIDTH'(1);
  end

endmodule

// File: doc/pipe_fetch_ctrl.md
# pipe_fetch_ctrl

Parametrised fetch and pipeline-control unit for the LC-3b pipelined CPU. It owns the PC, the instruction-fetch handshake and a one-entry fetch holding buffer. It also drives the per-stage valid bits and load enables that replace the tied-high `load_*` signals. It stalls on split instruction/data memory responses, inserts bubbles on load-use hazards, flushes on taken branches resolved in MEM, and counts stall cycles.

## Interface
- WIDTH, 16: word/address width.
- NSTAGES, 5: total pipeline stages, 5 or more. Pipeline register k (0..NSTAGES-2) feeds stage k+1.
  - reg0 = ID, reg1 = EX, reg NSTAGES-3 = MEM, reg NSTAGES-2 = WB.
  - Stages added beyond 5 sit between EX and MEM.
- RESET_PC, 0: PC value at reset.
- CNT_WIDTH, 16: stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- inst_mem_read  out  1  fetch request.
- inst_mem_addr  out  WIDTH  current PC.
- inst_mem_resp  in  1  fetch complete this cycle.
- inst_mem_rdata  in  WIDTH  fetched word.
- data_req  in  1  the MEM-stage control word requests a data access.
- data_mem_resp  in  1  data access complete.
- data_mem_go  out  1  qualifies datapath data_mem_read/write.
- br_taken  in  1  branch resolved taken in MEM.
- br_target  in  WIDTH  branch target.
- id_src_a, id_src_b  in  3  ID source registers.
- id_use_a, id_use_b  in  1  each source is actually read.
- id_is_load  in  1  ID instruction is a load.
- id_dest  in  3  ID destination register.
- if_ir  out  WIDTH  instruction presented to reg0.
- if_pc  out  WIDTH  PC+2 of that instruction.
- stage_load  out  NSTAGES-1  load enable per pipeline register.
- stage_valid  out  NSTAGES-1  registered valid bit per pipeline register.
- stall_count  out  CNT_WIDTH  saturating stall-cycle counter.

## Operation

Internal state:
- A shadow {valid, is_load, dest} pipeline tracks regs 0..MEM-1 and shifts with stage_load.

Combinational conditions:
- mvalid = stage_valid[MEM].
- dstall = mvalid & data_req & ~data_mem_resp.
- flush = mvalid & br_taken & ~dstall.
- luh = ~flush & stage_valid[0] & a used ID source equals the dest of any valid load in regs 1..MEM-1.
- adv (front advances) = flush | (~dstall & ~luh).
- data_mem_go = mvalid & data_req.

Register control:
- dstall:
  - stage_load = only the WB bit.
  - WB valid ← 0 (bubble).
  - All other registers and the PC hold.
- luh:
  - reg0 and the PC hold.
  - reg1 loads a bubble (valid 0).
  - Regs 2 and above advance.
- flush:
  - All registers load.
  - Valid of regs 0..MEM ← 0.
  - WB valid ← 1 (the branch itself).
- Otherwise:
  - All registers load, valid shifts.
  - reg0 valid comes from the fetch FSM.

Fetch FSM (reset state FETCH):
- FETCH: inst_mem_read = 1; if_ir = inst_mem_rdata; if_pc = PC+2.
  - resp & flush: discard the word; PC ← br_target.
  - resp & adv: reg0 valid ← 1; PC ← PC+2.
  - resp & ~adv: hold_ir ← rdata; PC ← PC+2; go to HOLD.
  - ~resp & flush: redir ← br_target; go to REDIRECT; reg0 valid ← 0.
  - ~resp & adv: reg0 valid ← 0 (bubble).
- HOLD: inst_mem_read = 0; if_ir = hold_ir; if_pc = PC.
  - flush: discard; PC ← br_target; go to FETCH.
  - adv: reg0 valid ← 1; go to FETCH.
- REDIRECT: inst_mem_read = 1 with the address unchanged; reg0 loads a bubble whenever adv.
  - resp: discard the word; PC ← redir; go to FETCH.
  - flush: redir ← br_target (not expected in operation).
- PC arithmetic is modulo 2^WIDTH; 0xFFFE+2 wraps to 0.
- stall_count increments on every cycle with dstall | luh and saturates at all-ones.

## Timing
- Reset (async, immediate):
  - PC = RESET_PC; state = FETCH.
  - stage_valid = 0; shadow bits = 0; hold_ir = 0; stall_count = 0.
  - inst_mem_read is forced 0 while reset is high.
- Combinational outputs: if_ir, if_pc, stage_load and data_mem_go depend on the current inputs and state.
- Registered: PC and stage_valid update at the clock edge.
- With zero-wait memory (resp high in the request cycle), throughput is 1 instruction/cycle. A fetch resolved at edge n is valid in reg0 after edge n.
- inst_mem_addr is stable from request until the resp cycle. An outstanding fetch is never abandoned.
- Load-use: exactly 1 bubble per dependent instruction for NSTAGES = 5; NSTAGES-4 bubbles worst case otherwise.
- Taken branch: the first target fetch is requested the cycle after the resolving edge (after resp when in REDIRECT).

## Test plan
- Reset, then resp tied 1 → addr 0x0000, 0x0002, 0x0004…; stage_valid 0001, 0011, 0111, 1111 over 4 edges; stall_count 0.
- resp low for 2 cycles at addr 0x0004 → addr held 3 cycles; 2 bubbles enter reg0 and propagate; stall_count unchanged.
- Load R3 in EX, ID uses src_a = 3 → one cycle with stage_load = 1110, reg1 valid 0, PC held; stall_count = 1.
- MEM valid, data_req = 1, data_mem_resp low 3 cycles → stage_load = 1000, WB valid 0, stall_count += 3. A fetch resp arriving during the stall enters HOLD (inst_mem_read 0) and the instruction issues on release.
- br_taken, target 0x0040, resp = 1 → next addr 0x0040 and valid bits 0..2 cleared. Repeat with the fetch outstanding → REDIRECT: old addr held until resp, then 0x0040.
- Assert reset in HOLD mid-stall → outputs immediately at reset values; after release, fetching resumes at RESET_PC.
